// File: rtl/shiftsubdiv.sv
// shiftsubdiv: sequential unsigned restoring divider, one quotient bit per clock.
//
// State table:
//   state  | meaning
//   S_IDLE | waiting for start; results of the last operation held on outputs
//   S_RUN  | shift-subtract loop, one iteration per edge, WIDTH iterations
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous reset, active low
//   start        request, sampled only while idle
//   A, B         dividend / divisor, captured on the accepting edge
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         high while an operation is in progress
//   done         single-cycle pulse, results valid from this cycle on
//   div_by_zero  set when the last accepted operation had B == 0
module shiftsubdiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // After each iteration the remainder is strictly below the divisor, so
  // its top bit is always zero and only WIDTH bits need storing; the
  // (WIDTH+1)-bit value exists only as the shifted compare operand.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remr_q, remr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_shift;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remr_q  <= remr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (B != '0)) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST)      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One restoring iteration. The subtraction is taken modulo 2^WIDTH: when
  // it is selected the true result is below the divisor and fits exactly.
  always_comb begin
    r_shift   = {rem_q, dvd_q[WIDTH-1]};
    q_bit     = (r_shift >= {1'b0, dvs_q});
    r_diff    = r_shift[WIDTH-1:0] - dvs_q;
    r_next    = q_bit ? r_diff : r_shift[WIDTH-1:0];
    dvd_shift = {dvd_q[WIDTH-2:0], q_bit};
  end

  // Datapath and outputs
  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    remr_d = remr_q;
    busy_d = busy_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B != '0) begin
            dvd_d  = A;
            dvs_d  = B;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            dbz_d  = 1'b0;
          end else begin
            quot_d = '1;
            remr_d = A;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        rem_d = r_next;
        dvd_d = dvd_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quot_d = dvd_shift;
          remr_d = r_next;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign quotient    = quot_q;
  assign remainder   = remr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shiftsubdiv.sv
module tb_shiftsubdiv;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0 = 0;

  shiftsubdiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .quotient(quotient), .remainder(remainder), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Present a one-cycle start; returns #1 after the accepting edge E0.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat = edges after E0, bcnt = busy samples seen.
  task automatic wait_done(output int lat, output int bcnt);
    bcnt = 0;
    while (done !== 1'b1 && (cyc - e0) < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
    end
    lat = cyc - e0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (quotient !== 8'd0) begin bad++; $display("FAIL reset_quot got=%0d exp=0", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL reset_rem got=%0d exp=0", remainder); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, bc;
    drive_start(8'd200, 8'd7);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b exp=0", done); end
    wait_done(lat, bc);
    total++; if (lat != 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    total++; if (bc != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL basic_quot got=%0d exp=28", quotient); end
    total++; if (remainder !== 8'd4) begin bad++; $display("FAIL basic_rem got=%0d exp=4", remainder); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    total++; if (quotient !== 8'd28) begin bad++; $display("FAIL basic_quot_hold got=%0d exp=28", quotient); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, t1, t2;
    drive_start(8'd255, 8'd1);
    wait_done(lat, bc);
    t1 = cyc;
    total++; if (quotient !== 8'd255) begin bad++; $display("FAIL b2b_quot1 got=%0d exp=255", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL b2b_rem1 got=%0d exp=0", remainder); end
    drive_start(8'd5, 8'd9);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    total++; if (quotient !== 8'd255) begin bad++; $display("FAIL b2b_prev_hold got=%0d exp=255", quotient); end
    wait_done(lat, bc);
    t2 = cyc;
    total++; if (t2 - t1 != 9) begin bad++; $display("FAIL b2b_gap got=%0d exp=9", t2 - t1); end
    total++; if (quotient !== 8'd0) begin bad++; $display("FAIL b2b_quot2 got=%0d exp=0", quotient); end
    total++; if (remainder !== 8'd5) begin bad++; $display("FAIL b2b_rem2 got=%0d exp=5", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int lat, bc;
    drive_start(8'd77, 8'd0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL dz_done got=%b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy got=%b exp=0", busy); end
    total++; if (quotient !== 8'd255) begin bad++; $display("FAIL dz_quot got=%0d exp=255", quotient); end
    total++; if (remainder !== 8'd77) begin bad++; $display("FAIL dz_rem got=%0d exp=77", remainder); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL dz_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_busy_after got=%b exp=0", busy); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag_hold got=%b exp=1", div_by_zero); end
    drive_start(8'd9, 8'd3);
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL dz_flag_clear got=%b exp=0", div_by_zero); end
    wait_done(lat, bc);
    total++; if (quotient !== 8'd3) begin bad++; $display("FAIL dz_next_quot got=%0d exp=3", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL dz_next_rem got=%0d exp=0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    drive_start(8'd100, 8'd10);
    while (cyc - e0 < 3) begin @(posedge clk); #1; end
    start = 1'b1; A = 8'd50; B = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; A = '0; B = '0;
    wait_done(lat, bc);
    total++; if (lat != 8) begin bad++; $display("FAIL ign_latency got=%0d exp=8", lat); end
    total++; if (quotient !== 8'd10) begin bad++; $display("FAIL ign_quot got=%0d exp=10", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL ign_rem got=%0d exp=0", remainder); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen;
    drive_start(8'd200, 8'd7);
    while (cyc - e0 < 3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (quotient !== 8'd0) begin bad++; $display("FAIL abort_quot got=%0d exp=0", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL abort_rem got=%0d exp=0", remainder); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    drive_start(8'd17, 8'd17);
    wait_done(lat, bc);
    total++; if (quotient !== 8'd1) begin bad++; $display("FAIL abort_next_quot got=%0d exp=1", quotient); end
    total++; if (remainder !== 8'd0) begin bad++; $display("FAIL abort_next_rem got=%0d exp=0", remainder); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [W-1:0] a, b, eq, er;
    logic [W-1:0] va [4] = '{8'd0, 8'd255, 8'd1, 8'd255};
    logic [W-1:0] vb [4] = '{8'd1, 8'd255, 8'd255, 8'd128};
    for (int i = 0; i < 150; i++) begin
      if (i < 4) begin a = va[i]; b = vb[i]; end
      else begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(1, 255)); end
      eq = a / b;
      er = a % b;
      drive_start(a, b);
      wait_done(lat, bc);
      total++;
      if (quotient !== eq || remainder !== er || lat != 8) begin
        bad++;
        $display("FAIL sweep a=%0d b=%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=8",
                 a, b, quotient, remainder, lat, eq, er);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shiftsubdiv.md
# shiftsubdiv

Sequential unsigned restoring divider: the shift-subtract counterpart of the datapath's shift-add multiplier. It produces one quotient bit per clock and returns a quotient and remainder from a one-cycle `start` request. It sits beside the multiplier in the multi-cycle CPU datapath and serves the divide/modulo instructions. The controller holds the instruction in its execute state until `done` pulses.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits (WIDTH ≥ 2).

Ports (one clock; reset is synchronous and active-low):
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  synchronous reset, active low, sampled on `clk`.
- `start`  input  1  request; sampled only while idle.
- `A`  input  WIDTH  dividend; captured on the accepting edge.
- `B`  input  WIDTH  divisor; captured on the accepting edge.
- `quotient`  output  WIDTH  registered quotient of the last completed operation.
- `remainder`  output  WIDTH  registered remainder of the last completed operation.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse; results are valid from this cycle on.
- `div_by_zero`  output  1  flag for the last operation; held until the next accepted start.

## Operation
- States: IDLE and RUN.
- Reset (`rst_n` = 0 at an edge):
  - state → IDLE.
  - `quotient`, `remainder`, `busy`, `done` and `div_by_zero` → 0.
  - Internal count, dividend shift register and partial remainder → 0.
  - Reset has priority over `start` and aborts any operation in flight; no `done` is produced for it.
- IDLE with `start` = 1 and `B` ≠ 0:
  - Load the dividend shift register with `A` and the divisor with `B`.
  - Clear the (WIDTH+1)-bit partial remainder.
  - Set count = 0, `busy` = 1, `div_by_zero` = 0; go to RUN.
- IDLE with `start` = 1 and `B` = 0:
  - Do not enter RUN.
  - Set `quotient` = all ones, `remainder` = `A`, `div_by_zero` = 1, `done` = 1.
  - `busy` stays 0.
- RUN, each edge (one iteration):
  - r' = {r[WIDTH-1:0], dvd[WIDTH-1]}.
  - If r' ≥ {1'b0, divisor}: r = r' − divisor and the quotient bit = 1.
  - Otherwise: r = r' and the quotient bit = 0.
  - The dividend register shifts left; the quotient bit enters at its LSB, so it becomes the quotient when the loop ends.
  - count increments.
- RUN, edge with count = WIDTH−1 (the last iteration):
  - Write the final quotient to `quotient`.
  - Write the final r[WIDTH-1:0] to `remainder`.
  - Set `done` = 1 and `busy` = 0; go to IDLE.
- `done` is forced to 0 on every edge where it is not explicitly set, so it is always a single-cycle pulse.
- `start` while in RUN is ignored; it is not queued and the operands are not re-sampled.
- `quotient` and `remainder` hold their values between operations. They change only at completion, so the previous result stays readable while `busy` = 1.
- Arithmetic: unsigned only; the partial remainder is WIDTH+1 bits so the compare never overflows. Required invariant: A = quotient·B + remainder, with remainder < B.

## Timing
- Accepting edge = E0.
- Normal divide: WIDTH iterations on edges E0+1 … E0+WIDTH.
  - `busy` is high from after E0 until after E0+WIDTH.
  - `done` is high, and the results are valid, in the cycle after E0+WIDTH: latency WIDTH cycles (8 for the default).
- Divide by zero: `done` and the results are valid in the cycle after E0 (latency 1).
- Back-to-back operation: `start` asserted in the same cycle as `done` is accepted, because the block is already IDLE. This gives a throughput of one divide per WIDTH+1 cycles.
- `start` held high continuously restarts the divider in every IDLE cycle.

## Test plan
- Reset, then A=200, B=7, start for 1 cycle -> `busy` high for 8 cycles; `done` pulses exactly 8 cycles after the start edge with `quotient`=28, `remainder`=4, `div_by_zero`=0.
- A=255, B=1, then A=5, B=9, issued back-to-back with start re-asserted in the `done` cycle -> 255/0, then 0/5; second `done` 9 cycles after the first.
- A=77, B=0 -> `done` 1 cycle later, `quotient`=255, `remainder`=77, `div_by_zero`=1, `busy` never high. A following A=9, B=3 -> `div_by_zero` clears at accept; result 3/0.
- A=100, B=10 accepted; at cycle 3 drive start with A=50, B=5 -> ignored; result 10/0 on schedule.
- A=200, B=7 accepted; `rst_n`=0 at cycle 4 -> all outputs 0 on the next edge and no `done` pulse. After release, A=17, B=17 -> 1/0.
- Random sweep of all A, B with B≠0 for WIDTH=8 -> quotient·B + remainder = A and remainder < B on every `done`.
